// File: rtl/booth_multiplier_if.sv
// Operand/result bundle for the Booth multiplier.
// The master drives start and the operands; the slave returns product, busy and done.
interface booth_multiplier_if #(
  parameter int WIDTH = 4
);
  logic                 start;
  logic [WIDTH-1:0]     multiplicand;
  logic [WIDTH-1:0]     multiplier;
  logic [2*WIDTH-1:0]   product;
  logic                 busy;
  logic                 done;

  modport master (
    output start, multiplicand, multiplier,
    input  product, busy, done
  );

  modport slave (
    input  start, multiplicand, multiplier,
    output product, busy, done
  );
endinterface

// File: rtl/booth_multiplier.sv
// Radix-2 Booth sequential signed multiplier: one add/subtract plus an arithmetic shift per cycle.
// Product and done appear WIDTH+1 edges after the accepting edge; back-to-back every WIDTH+2 cycles.
module booth_multiplier #(
  parameter int WIDTH = 4
) (
  input logic              clk,
  input logic              rst_n,
  booth_multiplier_if.slave bus
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    FINISH
  } state_t;

  state_t               state_q, state_d;
  logic [WIDTH:0]       a_q, a_d;
  logic [WIDTH-1:0]     q_q, q_d;
  logic                 qm1_q, qm1_d;
  logic [WIDTH-1:0]     m_q, m_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [2*WIDTH-1:0]   product_q, product_d;
  logic                 done_q, done_d;

  logic [WIDTH:0]       m_ext;
  logic                 do_sub;
  logic [WIDTH:0]       addsub;
  logic [WIDTH:0]       a_new;

  // Single WIDTH+1-bit adder; subtraction is add of the inverted operand with carry-in.
  always_comb begin
    m_ext  = {m_q[WIDTH-1], m_q};
    do_sub = q_q[0] & ~qm1_q;
    addsub = a_q + (do_sub ? ~m_ext : m_ext) + {{WIDTH{1'b0}}, do_sub};
    a_new  = (q_q[0] ^ qm1_q) ? addsub : a_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      a_q       <= '0;
      q_q       <= '0;
      qm1_q     <= 1'b0;
      m_q       <= '0;
      cnt_q     <= '0;
      product_q <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      a_q       <= a_d;
      q_q       <= q_d;
      qm1_q     <= qm1_d;
      m_q       <= m_d;
      cnt_q     <= cnt_d;
      product_q <= product_d;
      done_q    <= done_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    q_d       = q_q;
    qm1_d     = qm1_q;
    m_d       = m_q;
    cnt_d     = cnt_q;
    product_d = product_q;
    done_d    = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          m_d     = bus.multiplicand;
          q_d     = bus.multiplier;
          a_d     = '0;
          qm1_d   = 1'b0;
          cnt_d   = CW'(WIDTH);
          state_d = CALC;
        end
      end

      CALC: begin
        {a_d, q_d, qm1_d} = {a_new[WIDTH], a_new, q_q};
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          state_d = FINISH;
        end
      end

      FINISH: begin
        // Result is registered on the edge leaving FINISH so done lands at edge WIDTH+1.
        product_d = {a_q[WIDTH-1:0], q_q};
        done_d    = 1'b1;
        state_d   = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign bus.product = product_q;
  assign bus.done    = done_q;
  assign bus.busy    = (state_q != IDLE);

endmodule

// File: tb/tb_booth_multiplier.sv
// Self-checking bench for booth_multiplier: cycle-level reference model plus directed vectors.
module tb_booth_multiplier;

  localparam int W = 4;

  logic clk;
  logic rst_n;

  booth_multiplier_if #(.WIDTH(W)) bus ();

  booth_multiplier #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int passed = 0;
  int done_count = 0;

  // Reference model state
  int             m_cnt = 0;
  logic [2*W-1:0] m_pend = '0;
  logic [2*W-1:0] m_prod = '0;
  logic           m_done = 1'b0;

  function automatic logic [2*W-1:0] ref_mul(input logic [W-1:0] a, input logic [W-1:0] b);
    logic signed [W-1:0] sa;
    logic signed [W-1:0] sb;
    int p;
    sa = a;
    sb = b;
    p  = int'(sa) * int'(sb);
    return p[2*W-1:0];
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Model: an accepted request completes WIDTH+1 edges later; requests while busy are dropped.
  always @(posedge clk) begin
    m_done = 1'b0;
    if (!rst_n) begin
      m_cnt  = 0;
      m_prod = '0;
    end else if (m_cnt == 0) begin
      if (bus.start === 1'b1) begin
        m_cnt  = W + 1;
        m_pend = ref_mul(bus.multiplicand, bus.multiplier);
      end
    end else begin
      m_cnt--;
      if (m_cnt == 0) begin
        m_done = 1'b1;
        m_prod = m_pend;
      end
    end
    #1;
    chk("cyc_product", 32'(bus.product), 32'(m_prod));
    chk("cyc_busy", 32'(bus.busy), 32'(m_cnt != 0));
    chk("cyc_done", 32'(bus.done), 32'(m_done));
    if (bus.done === 1'b1) done_count++;
  end

  // Drive a request now; it is sampled at the next rising edge, then operands are scrambled.
  task automatic issue_op(input logic [W-1:0] m, input logic [W-1:0] q);
    bus.start        = 1'b1;
    bus.multiplicand = m;
    bus.multiplier   = q;
    @(posedge clk);
    #2;
    bus.start        = 1'b0;
    bus.multiplicand = W'($urandom);
    bus.multiplier   = W'($urandom);
  endtask

  // Counts edges after the accepting edge until done; 20 means no done was seen.
  task automatic wait_done(output int lat);
    lat = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #1;
      lat++;
      if (bus.done === 1'b1) break;
    end
  endtask

  task automatic run_op(input logic [W-1:0] m, input logic [W-1:0] q,
                        output logic [2*W-1:0] p, output int lat);
    @(negedge clk);
    issue_op(m, q);
    wait_done(lat);
    p = bus.product;
  endtask

  logic [2*W-1:0] p;
  int             lat;
  int             dc0;
  int             n_done;
  int             edge_at [2];
  logic [2*W-1:0] prod_at [2];

  initial begin
    rst_n            = 1'b0;
    bus.start        = 1'b0;
    bus.multiplicand = '0;
    bus.multiplier   = '0;
    #3;
    chk("rst_product", 32'(bus.product), 32'h0);
    chk("rst_busy", 32'(bus.busy), 32'h0);
    chk("rst_done", 32'(bus.done), 32'h0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Basic 5*3
    @(negedge clk);
    issue_op(4'd5, 4'd3);
    chk("basic_busy_after_accept", 32'(bus.busy), 32'h1);
    wait_done(lat);
    chk("basic_latency", 32'(lat), 32'(W + 1));
    chk("basic_product", 32'(bus.product), 32'h0F);
    chk("model_5x3", 32'(m_prod), 32'h0F);
    chk("basic_busy_at_done", 32'(bus.busy), 32'h0);

    // Signed corners
    run_op(4'h8, 4'h8, p, lat);
    chk("neg8xneg8", 32'(p), 32'h40);
    chk("model_neg8xneg8", 32'(m_prod), 32'h40);
    chk("neg8xneg8_lat", 32'(lat), 32'(W + 1));
    run_op(4'h8, 4'h7, p, lat);
    chk("neg8x7", 32'(p), 32'hC8);
    run_op(4'h3, 4'hB, p, lat);
    chk("3xneg5", 32'(p), 32'hF1);
    chk("model_3xneg5", 32'(m_prod), 32'hF1);

    // Start while busy is ignored
    dc0 = done_count;
    @(negedge clk);
    issue_op(4'd5, 4'd3);
    @(negedge clk);
    bus.start = 1'b1; bus.multiplicand = 4'd2; bus.multiplier = 4'd2;
    @(negedge clk);
    bus.start = 1'b0;
    wait_done(lat);
    chk("busy_start_product", 32'(bus.product), 32'h0F);
    repeat (12) @(negedge clk);
    chk("busy_start_one_done", 32'(done_count - dc0), 32'h1);
    chk("busy_start_product_held", 32'(bus.product), 32'h0F);

    // Reset in the second CALC cycle of 7*7
    dc0 = done_count;
    @(negedge clk);
    issue_op(4'd7, 4'd7);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk("midrst_product", 32'(bus.product), 32'h0);
    chk("midrst_busy", 32'(bus.busy), 32'h0);
    chk("midrst_done", 32'(bus.done), 32'h0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    issue_op(4'd7, 4'd7);
    chk("midrst_no_done", 32'(done_count - dc0), 32'h0);
    wait_done(lat);
    chk("postrst_latency", 32'(lat), 32'(W + 1));
    chk("postrst_7x7", 32'(bus.product), 32'h31);

    // Back-to-back with start held high
    n_done = 0;
    @(negedge clk);
    bus.start = 1'b1; bus.multiplicand = 4'd4; bus.multiplier = 4'hE;
    @(posedge clk);
    #2;
    bus.multiplicand = 4'hF; bus.multiplier = 4'hF;
    for (int e = 1; e <= 30; e++) begin
      @(posedge clk);
      #1;
      if (bus.done === 1'b1) begin
        edge_at[n_done] = e;
        prod_at[n_done] = bus.product;
        n_done++;
        if (n_done == 2) break;
      end
    end
    bus.start = 1'b0;
    chk("b2b_done_count", 32'(n_done), 32'h2);
    if (n_done == 2) begin
      chk("b2b_first_edge", 32'(edge_at[0]), 32'(W + 1));
      chk("b2b_spacing", 32'(edge_at[1] - edge_at[0]), 32'(W + 2));
      chk("b2b_prod0", 32'(prod_at[0]), 32'hF8);
      chk("b2b_prod1", 32'(prod_at[1]), 32'h01);
    end

    // Exhaustive sweep
    for (int a = 0; a < (1 << W); a++) begin
      for (int b = 0; b < (1 << W); b++) begin
        logic [W-1:0] ma;
        logic [W-1:0] qb;
        ma = W'(a);
        qb = W'(b);
        run_op(ma, qb, p, lat);
        chk("sweep_product", 32'(p), 32'(ref_mul(ma, qb)));
        chk("sweep_latency", 32'(lat), 32'(W + 1));
      end
    end

    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
